// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : alu_pkg                                                        |
// | Purpose   : Shared types and constants for the 4-bit ALU and its result    |
// |             checker (opcodes, flag bundle, checker FSM states).            |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
package alu_pkg;

  localparam int ALU_WIDTH = 4;

  // ALU opcodes; encodings match the control bus of the ALU under check
  typedef enum logic [2:0] {
    ADD = 3'b000,
    SUB = 3'b001,
    AND = 3'b010,
    OR  = 3'b011,
    XOR = 3'b100,
    SHL = 3'b101,
    SHR = 3'b110,
    NOT = 3'b111
  } alu_op_e;

  // Flag bundle; field order gives {n,z,c,v} when used as a packed vector
  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } alu_flags_t;

  // Checker run states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_golden.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu_golden                                                     |
// | Purpose   : Combinational reference model of the ALU. Produces the result  |
// |             and n/z/c/v flags the real ALU is expected to return.          |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module alu_golden
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  input  logic             carryin,
  output logic [WIDTH-1:0] res,
  output alu_flags_t       flags
);

  localparam int C_MSB = WIDTH - 1;

  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_res;
  logic             w_c;
  logic             w_v;

  // Reference datapath: arithmetic uses a WIDTH+1 sum so bit WIDTH is the carry
  always_comb begin
    w_b_eff = (alu_op_e'(control) == SUB) ? ~b : b;
    w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{WIDTH{1'b0}}, carryin};
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    case (alu_op_e'(control))
      ADD, SUB: begin
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        // Signed overflow: operands agree in sign but the result does not
        w_v   = (a[C_MSB] == w_b_eff[C_MSB]) && (w_res[C_MSB] != a[C_MSB]);
      end
      AND: w_res = a & b;
      OR:  w_res = a | b;
      XOR: w_res = a ^ b;
      SHL: begin
        w_res = {a[WIDTH-2:0], 1'b0};
        w_c   = a[C_MSB];
      end
      SHR: begin
        w_res = {1'b0, a[WIDTH-1:1]};
        w_c   = a[0];
      end
      NOT: w_res = ~a;
      default: w_res = '0;
    endcase
  end

  assign res     = w_res;
  assign flags.n = w_res[C_MSB];
  assign flags.z = (w_res == '0);
  assign flags.c = w_c;
  assign flags.v = w_v;

endmodule : alu_golden
`default_nettype wire

// File: rtl/alu_result_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : alu_result_checker                                             |
// | Purpose   : Scoreboard beside the ALU. Compares every valid ALU response   |
// |             with alu_golden over a run of N_VECTORS samples and tallies    |
// |             pass/fail counts.                                              |
// | Option    : MISMATCH_LOG_EN adds log_* outputs holding the first failing   |
// |             sample of the current run.                                     |
// | Revision  : 1.0  initial release                                           |
// +----------------------------------------------------------------------------+
module alu_result_checker
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int N_VECTORS = 32,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sample_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       control,
  input  logic             carryin,
  input  logic [WIDTH-1:0] result,
  input  logic             n,
  input  logic             z,
  input  logic             c,
  input  logic             v,
  output logic             busy,
  output logic             done,
  output logic             all_pass,
  output logic [CNT_W-1:0] pass_count,
  output logic [CNT_W-1:0] fail_count,
  output logic             mismatch
`ifdef MISMATCH_LOG_EN
  ,
  output logic             log_valid,
  output logic [WIDTH-1:0] log_a,
  output logic [WIDTH-1:0] log_b,
  output logic [2:0]       log_ctrl,
  output logic             log_cin,
  output logic [WIDTH+3:0] log_exp,
  output logic [WIDTH+3:0] log_got
`endif
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(N_VECTORS - 1);
  localparam logic [CNT_W-1:0] C_MAX  = '1;

  chk_state_e       r_state;
  chk_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_seen;
  logic [CNT_W-1:0] r_pass;
  logic [CNT_W-1:0] r_fail;
  logic             r_mismatch;

  logic [WIDTH-1:0] w_gold_res;
  alu_flags_t       w_gold_flags;
  logic [WIDTH+3:0] w_exp;
  logic [WIDTH+3:0] w_got;
  logic             w_accept;
  logic             w_match;
  logic             w_last;
  logic             w_start_ok;

  alu_golden #(
    .WIDTH (WIDTH)
  ) u_golden (
    .a       (a),
    .b       (b),
    .control (control),
    .carryin (carryin),
    .res     (w_gold_res),
    .flags   (w_gold_flags)
  );

  assign w_exp      = {w_gold_res, w_gold_flags};
  assign w_got      = {result, n, z, c, v};
  assign w_match    = (w_got == w_exp);
  assign w_accept   = (r_state == RUN) && sample_valid;
  assign w_last     = (r_seen == C_LAST);
  // start is only meaningful when no run is in progress
  assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: a run ends on the edge that accepts the final sample
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_accept && w_last) w_state_nxt = DONE;
      DONE:    if (start) w_state_nxt = RUN;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Sample, pass and fail counters plus the registered mismatch pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seen     <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_mismatch <= 1'b0;
    end else if (w_start_ok) begin
      r_seen     <= '0;
      r_pass     <= '0;
      r_fail     <= '0;
      r_mismatch <= 1'b0;
    end else begin
      r_mismatch <= w_accept && !w_match;
      if (w_accept) begin
        r_seen <= r_seen + 1'b1;
        if (w_match) begin
          if (r_pass != C_MAX) r_pass <= r_pass + 1'b1;
        end else begin
          if (r_fail != C_MAX) r_fail <= r_fail + 1'b1;
        end
      end
    end
  end

`ifdef MISMATCH_LOG_EN
  logic             r_log_valid;
  logic [WIDTH-1:0] r_log_a;
  logic [WIDTH-1:0] r_log_b;
  logic [2:0]       r_log_ctrl;
  logic             r_log_cin;
  logic [WIDTH+3:0] r_log_exp;
  logic [WIDTH+3:0] r_log_got;

  // Capture only the first failing sample; later failures leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      r_log_valid <= 1'b0;
      r_log_a     <= '0;
      r_log_b     <= '0;
      r_log_ctrl  <= '0;
      r_log_cin   <= 1'b0;
      r_log_exp   <= '0;
      r_log_got   <= '0;
    end else if (w_start_ok) begin
      r_log_valid <= 1'b0;
    end else if (w_accept && !w_match && !r_log_valid) begin
      r_log_valid <= 1'b1;
      r_log_a     <= a;
      r_log_b     <= b;
      r_log_ctrl  <= control;
      r_log_cin   <= carryin;
      r_log_exp   <= w_exp;
      r_log_got   <= w_got;
    end
  end

  assign log_valid = r_log_valid;
  assign log_a     = r_log_a;
  assign log_b     = r_log_b;
  assign log_ctrl  = r_log_ctrl;
  assign log_cin   = r_log_cin;
  assign log_exp   = r_log_exp;
  assign log_got   = r_log_got;
`endif

  assign busy       = (r_state == RUN);
  assign done       = (r_state == DONE);
  assign all_pass   = done && (r_fail == '0);
  assign pass_count = r_pass;
  assign fail_count = r_fail;
  assign mismatch   = r_mismatch;

endmodule : alu_result_checker
`default_nettype wire
